// File: rtl/serial_sub_16_bit.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin, DIGIT bits per clock.
// Computed as a + ~b + ~bin through shift registers, with a start/busy/done handshake.
module serial_sub_16_bit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $fatal(1, "serial_sub_16_bit: DIGIT must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic [CW-1:0]    count_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;

    logic [DIGIT:0]   sum_next;
    logic [WIDTH-1:0] res_next;
    logic             accept;
    logic             last;

    always_comb begin
        sum_next = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, ~b_reg[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_reg};
        // New sum digit enters at the MSB end so the result ends up LSB-aligned after N steps.
        res_next = (res_reg >> DIGIT) | (WIDTH'(sum_next[DIGIT-1:0]) << (WIDTH - DIGIT));
        accept   = start && (state_reg == IDLE || state_reg == DONE);
        last     = (count_reg == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        res_reg   <= '0;
                        carry_reg <= ~bin;
                        count_reg <= '0;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b[WIDTH-1];
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    res_reg   <= res_next;
                    carry_reg <= sum_next[DIGIT];
                    count_reg <= count_reg + 1'b1;
                    if (last) begin
                        diff      <= res_next;
                        bout      <= ~sum_next[DIGIT];
                        ovf       <= (a_msb_reg != b_msb_reg) && (res_next[WIDTH-1] != a_msb_reg);
                        zero      <= (res_next == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_16_bit.sv
// Directed and random checks of serial_sub_16_bit at DIGIT=1 and DIGIT=4 side by side.
module tb_serial_sub_16_bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;

    logic        busy1, done1, bout1, ovf1, zero1;
    logic [15:0] diff1;
    logic        busy4, done4, bout4, ovf4, zero4;
    logic [15:0] diff4;

    int checks = 0;
    int errors = 0;
    int lat1, lat4, busy_cnt;

    always #5 clk = ~clk;

    serial_sub_16_bit #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1), .zero(zero1)
    );

    serial_sub_16_bit #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4), .zero(zero4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then count edges until each instance raises done.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cnt = int'(busy1);
        lat1 = 0;
        lat4 = 0;
        for (int k = 1; k <= 40 && lat1 == 0; k++) begin
            @(posedge clk);
            #1;
            if (done1 && lat1 == 0) lat1 = k;
            if (done4 && lat4 == 0) lat4 = k;
            if (busy1) busy_cnt++;
        end
        check("latency_d1", lat1, 16);
        check("latency_d4", lat4, 4);
        $display("op a=%h b=%h bin=%0d -> d1 diff=%h bout=%0d ovf=%0d zero=%0d | d4 diff=%h",
                 ta, tb, tbin, diff1, bout1, ovf1, zero1, diff4);
    endtask

    task automatic check_res(input string tag, input logic [15:0] ed, input logic eb,
                             input logic eo, input logic ez);
        check({tag, "_diff1"}, diff1, ed);
        check({tag, "_flags1"}, {bout1, ovf1, zero1}, {eb, eo, ez});
        check({tag, "_diff4"}, diff4, ed);
        check({tag, "_flags4"}, {bout4, ovf4, zero4}, {eb, eo, ez});
    endtask

    initial begin
        logic [16:0] m;
        logic [15:0] ra, rb;
        logic        rbin, eovf;
        int          seen_done;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs1", {busy1, done1, diff1, bout1, ovf1, zero1}, 0);
        check("reset_outs4", {busy4, done4, diff4, bout4, ovf4, zero4}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(16'hFEBF, 16'h5555, 1'b0);
        check("busy_cycles", busy_cnt, 16);
        check_res("febf", 16'hA96A, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("done_one_cycle", done1, 1'b0);
        check("hold_after_done", diff1, 16'hA96A);

        do_op(16'h0000, 16'h0001, 1'b0);
        check_res("zero_m1", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0);
        check_res("min_m1", 16'h7FFF, 1'b0, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0);
        check_res("max_mneg", 16'h8000, 1'b1, 1'b1, 1'b0);
        do_op(16'h1234, 16'h1233, 1'b1);
        check_res("bin_zero", 16'h0000, 1'b0, 1'b0, 1'b1);
        // Called while dut1 is in its DONE cycle: accepted back-to-back.
        do_op(16'h0005, 16'h0003, 1'b0);
        check_res("back2back", 16'h0002, 1'b0, 1'b0, 1'b0);

        // start while busy is ignored by dut1
        @(negedge clk);
        a = 16'h0100; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; bin = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        lat1 = 0;
        for (int k = 0; k < 40 && lat1 == 0; k++) begin
            @(posedge clk);
            #1;
            if (done1) lat1 = 1;
        end
        check("ignore_done_seen", lat1, 1);
        check("ignore_diff", diff1, 16'h00FF);
        check("ignore_flags", {bout1, ovf1, zero1}, 3'b000);

        // reset mid-operation
        @(negedge clk);
        a = 16'h0009; b = 16'h0002; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst1", {busy1, done1, diff1, bout1, ovf1, zero1}, 0);
        check("async_rst4", {busy4, done4, diff4, bout4, ovf4, zero4}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done1 || done4) seen_done++;
        end
        check("no_done_after_rst", seen_done, 0);
        check("outs_stay_zero", {busy1, diff1, bout1, ovf1, zero1}, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rbin = 1'($urandom);
            if (i == 0) begin ra = 16'h0000; rb = 16'hFFFF; rbin = 1'b1; end
            m = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbin};
            eovf = (ra[15] != rb[15]) && (m[15] != ra[15]);
            do_op(ra, rb, rbin);
            check_res("rand", m[15:0], m[16], eovf, m[15:0] == 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_sub_16_bit.md
Name: serial_sub_16_bit

Overview:
- Multi-cycle, digit-serial two's-complement subtractor. Computes diff = a - b - bin.
- Subtractor counterpart to the team's 16-bit ripple-carry adder.
- Internally it adds a, the complement of b, and the complement of bin, DIGIT bits per clock, using a shift-register datapath.
- Used where area matters more than latency. It has a start/done handshake toward the controller.

Parameters:
- WIDTH, 16: operand and result width in bits.
- DIGIT, 1: bits processed per cycle. Must divide WIDTH exactly; elaboration fails otherwise.

Ports:
- clk  input  1  single clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled on rising clk
- a  input  WIDTH  minuend, captured when start is accepted
- b  input  WIDTH  subtrahend, captured when start is accepted
- bin  input  1  borrow-in, captured when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results update
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out: 1 when unsigned a < b + bin
- ovf  output  1  signed overflow of the subtraction
- zero  output  1  diff equals 0

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset: state = IDLE. busy, done, diff, bout, ovf and zero are all 0. Internal registers and counter are cleared.
- Reset mid-operation: aborts immediately. No done pulse is produced and the outputs return to 0.
- Definition: N = WIDTH/DIGIT.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: capture a, b and bin; carry = ~bin; count = 0; go to RUN; busy=1 from the next cycle.
  - Otherwise stay in IDLE.
- RUN, at each edge:
  - Add the low DIGIT bits of the a shift register, the complement of the low DIGIT bits of the b shift register, and carry.
  - Shift the DIGIT sum bits into the MSB end of the result register. Shift both operand registers right by DIGIT.
  - Update carry with the carry-out of that DIGIT-bit add. count increments.
  - On the Nth RUN edge:
    - Load diff from the completed result register.
    - Set bout = ~final carry.
    - Set ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured a and b.
    - Set zero = (diff == 0).
    - done=1, busy=0, go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1 during it.
  - Next edge: done=0. If start=1, the operation is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: done is high in the cycle that follows N rising edges after the edge that accepted start.
  - WIDTH=16, DIGIT=1: 16 cycles.
  - WIDTH=16, DIGIT=4: 4 cycles.
- start while busy=1: ignored. Captured operands and the computation are unaffected.
- Changes to a, b or bin after acceptance have no effect on the result.
- diff, bout, ovf and zero hold their values from the last completion until the next completion or a reset. They never show partial results.
- bin handling: carry-in is ~bin, so bin=0 gives a plain a - b.
- Wrap-around: the result is modulo 2^WIDTH with no saturation. bout and ovf report the wrap.

Test Plan:
- Reset, then a=16'hFEBF, b=16'h5555, bin=0, start pulse -> busy high for 16 cycles; done pulse; diff=16'hA96A, bout=0, ovf=0, zero=0.
- a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, ovf=0, zero=0.
- a=16'h8000, b=16'h0001, bin=0 -> diff=16'h7FFF, bout=0, ovf=1; also a=16'h7FFF, b=16'hFFFF -> diff=16'h8000, ovf=1, bout=1.
- a=16'h1234, b=16'h1233, bin=1 -> diff=16'h0000, zero=1, bout=0. Then start held high in the DONE cycle with a=16'h0005, b=16'h0003 -> second done after 16 more cycles with diff=16'h0002.
- Start accepted; at cycle 5 assert start with new operands -> ignored, first result intact. Second run: assert rst at cycle 8 -> busy=0, all outputs 0 asynchronously, no done pulse ever appears.
- DIGIT=4 instance, a=16'hFEBF, b=16'h5555 -> done after 4 cycles, diff=16'hA96A; random 1000-vector comparison against a-b-bin for both DIGIT values.
